// File: rtl/video_window_calc.sv
// Centred output window from encoded aspect-ratio/size words and the HDMI resolution.
// Serial shift-add multiplier and restoring divider; recomputes whenever any input changes.
module video_window_calc #(
  parameter int unsigned MAX_LAT = 64
) (
  input  logic        CLK_VIDEO,
  input  logic        RESET,
  input  logic [11:0] HDMI_WIDTH,
  input  logic [11:0] HDMI_HEIGHT,
  input  logic [12:0] ARX,
  input  logic [12:0] ARY,
  output logic [11:0] HMIN,
  output logic [11:0] HMAX,
  output logic [11:0] VMIN,
  output logic [11:0] VMAX,
  output logic        VALID
);

  // Worst case: detect + START + 2 x (12 mul + 12 div) + CMP + CENTER, VALID on the next edge.
  localparam int unsigned CalcCycles = 52;

  if (CalcCycles > MAX_LAT) begin : g_lat_check
    $error("MAX_LAT is below the fixed computation latency");
  end

  typedef enum logic [3:0] {
    StIdle, StStart, StMul1, StDiv1, StCmp, StMul2, StDiv2, StCenter, StDone
  } state_e;

  state_e state_q, state_d;

  logic [11:0] snap_w_q, snap_h_q;
  logic [12:0] snap_arx_q, snap_ary_q;
  logic [3:0]  cnt_q;
  logic [23:0] prod_q, mcand_q;
  logic [11:0] mplier_q;
  logic [11:0] rem_q, dvd_q, quo_q;
  logic        sat_q;
  logic [11:0] w_q, h_q;
  logic [11:0] hmin_q, hmax_q, vmin_q, vmax_q;
  logic        valid_q;

  logic        in_change, zero_dim, abs_mode, ratio_deg, last_step;
  logic        take_snap, load_out;
  logic [23:0] prod_nx;
  logic [11:0] dvsr, rem_sub, rem_nx, quo_nx, quot_fin, quot_cur;
  logic [12:0] rem_sh;
  logic        div_ge, div_done;
  logic [11:0] abs_w, abs_h;
  logic [11:0] hspan, vspan, hmin_c, hmax_c, vmin_c, vmax_c;

  assign in_change = {HDMI_WIDTH, HDMI_HEIGHT, ARX, ARY} !=
                     {snap_w_q, snap_h_q, snap_arx_q, snap_ary_q};
  assign zero_dim  = (snap_w_q == 12'd0) || (snap_h_q == 12'd0);
  assign abs_mode  = snap_arx_q[12];
  assign ratio_deg = (snap_arx_q[11:0] == 12'd0) || (snap_ary_q[11:0] == 12'd0);
  assign last_step = (cnt_q == 4'd11);

  assign abs_w = ((snap_arx_q[11:0] == 12'd0) || (snap_arx_q[11:0] > snap_w_q)) ?
                 snap_w_q : snap_arx_q[11:0];
  assign abs_h = ((snap_ary_q[11:0] == 12'd0) || (snap_ary_q[11:0] > snap_h_q)) ?
                 snap_h_q : snap_ary_q[11:0];

  // Multiplier step
  assign prod_nx = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

  // Pass 1 divides by ARY, pass 2 by ARX; the divisor is also needed at the end of each MUL.
  assign dvsr = ((state_q == StMul1) || (state_q == StDiv1)) ? snap_ary_q[11:0] :
                                                               snap_arx_q[11:0];
  assign rem_sh   = {rem_q, dvd_q[11]};
  assign div_ge   = rem_sh >= {1'b0, dvsr};
  assign rem_sub  = rem_sh[11:0] - dvsr;
  assign rem_nx   = div_ge ? rem_sub : rem_sh[11:0];
  assign quo_nx   = {quo_q[10:0], div_ge};
  assign div_done = sat_q || last_step;
  assign quot_fin = sat_q ? 12'hfff : quo_nx;
  assign quot_cur = sat_q ? 12'hfff : quo_q;

  assign hspan  = snap_w_q - w_q;
  assign vspan  = snap_h_q - h_q;
  assign hmin_c = hspan >> 1;
  assign vmin_c = vspan >> 1;
  assign hmax_c = hmin_c + w_q - 12'd1;
  assign vmax_c = vmin_c + h_q - 12'd1;

  always_ff @(posedge CLK_VIDEO) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   state_d = StStart;
      StStart:  state_d = (zero_dim || abs_mode || ratio_deg) ? StCenter : StMul1;
      StMul1:   if (last_step) state_d = StDiv1;
      StDiv1:   if (div_done) state_d = StCmp;
      StCmp:    state_d = (quot_cur <= snap_w_q) ? StCenter : StMul2;
      StMul2:   if (last_step) state_d = StDiv2;
      StDiv2:   if (div_done) state_d = StCenter;
      StCenter: state_d = StDone;
      StDone:   state_d = StDone;
      default:  state_d = StIdle;
    endcase
    if ((state_q != StIdle) && in_change) state_d = StStart;
  end

  always_comb begin
    take_snap = (state_q == StIdle) || in_change;
    load_out  = (state_q == StCenter) && !in_change;
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (RESET) begin
      snap_w_q   <= '0;
      snap_h_q   <= '0;
      snap_arx_q <= '0;
      snap_ary_q <= '0;
      cnt_q      <= '0;
      prod_q     <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      quo_q      <= '0;
      sat_q      <= 1'b0;
      w_q        <= '0;
      h_q        <= '0;
      hmin_q     <= '0;
      hmax_q     <= '0;
      vmin_q     <= '0;
      vmax_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      if (take_snap) begin
        snap_w_q   <= HDMI_WIDTH;
        snap_h_q   <= HDMI_HEIGHT;
        snap_arx_q <= ARX;
        snap_ary_q <= ARY;
        valid_q    <= 1'b0;
      end
      case (state_q)
        StStart: begin
          cnt_q    <= '0;
          prod_q   <= '0;
          mcand_q  <= {12'd0, snap_h_q};
          mplier_q <= snap_arx_q[11:0];
          if (abs_mode) begin
            w_q <= abs_w;
            h_q <= abs_h;
          end else begin
            w_q <= snap_w_q;
            h_q <= snap_h_q;
          end
        end
        StMul1, StMul2: begin
          prod_q   <= prod_nx;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 4'd1;
          if (last_step) begin
            // High half >= divisor means the quotient needs more than 12 bits: saturate.
            cnt_q <= '0;
            rem_q <= prod_nx[23:12];
            dvd_q <= prod_nx[11:0];
            quo_q <= '0;
            sat_q <= prod_nx[23:12] >= dvsr;
          end
        end
        StDiv1, StDiv2: begin
          rem_q <= rem_nx;
          dvd_q <= dvd_q << 1;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + 4'd1;
          if ((state_q == StDiv2) && div_done) begin
            h_q <= (quot_fin > snap_h_q) ? snap_h_q : quot_fin;
          end
        end
        StCmp: begin
          cnt_q    <= '0;
          prod_q   <= '0;
          mcand_q  <= {12'd0, snap_w_q};
          mplier_q <= snap_ary_q[11:0];
          if (quot_cur <= snap_w_q) begin
            w_q <= quot_cur;
            h_q <= snap_h_q;
          end else begin
            w_q <= snap_w_q;
          end
        end
        default: ;
      endcase
      if (load_out) begin
        valid_q <= 1'b1;
        if (zero_dim) begin
          hmin_q <= '0;
          hmax_q <= '0;
          vmin_q <= '0;
          vmax_q <= '0;
        end else begin
          hmin_q <= hmin_c;
          hmax_q <= hmax_c;
          vmin_q <= vmin_c;
          vmax_q <= vmax_c;
        end
      end
    end
  end

  assign HMIN  = hmin_q;
  assign HMAX  = hmax_q;
  assign VMIN  = vmin_q;
  assign VMAX  = vmax_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_video_window_calc.sv
// Self-checking bench for video_window_calc: directed table, abort/reset sequences and
// randomized vectors against an arithmetic reference model.
module tb_video_window_calc;

  localparam int MaxLat = 64;

  logic        clk = 1'b0;
  logic        RESET;
  logic [11:0] w, h;
  logic [12:0] arx, ary;
  logic [11:0] hmin, hmax, vmin, vmax;
  logic        valid;

  int checks = 0;
  int passes = 0;
  int p_hmin = 0, p_hmax = 0, p_vmin = 0, p_vmax = 0;

  always #5 clk = ~clk;

  video_window_calc #(.MAX_LAT(MaxLat)) dut (
    .CLK_VIDEO   (clk),
    .RESET       (RESET),
    .HDMI_WIDTH  (w),
    .HDMI_HEIGHT (h),
    .ARX         (arx),
    .ARY         (ary),
    .HMIN        (hmin),
    .HMAX        (hmax),
    .VMIN        (vmin),
    .VMAX        (vmax),
    .VALID       (valid)
  );

  typedef struct {
    int wd, ht, ax, ay;
    int hmn, hmx, vmn, vmx;
  } vec_t;

  vec_t tbl[12];

  task automatic check_cond(input string name, input bit ok, input int act, input int req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic check(input string name, input int act, input int req);
    check_cond(name, act == req, act, req);
  endtask

  // Window from the rules: pick W/H by mode, then centre; span ends wrap at 12 bits.
  function automatic void ref_win(input int wd, input int ht, input int ax, input int ay,
                                  output int hmn, output int hmx, output int vmn,
                                  output int vmx);
    int ww, hh, axm, aym, wc;
    axm = ax % 4096;
    aym = ay % 4096;
    if (wd == 0 || ht == 0) begin
      hmn = 0; hmx = 0; vmn = 0; vmx = 0;
      return;
    end
    if (ax >= 4096) begin
      ww = (axm == 0 || axm > wd) ? wd : axm;
      hh = (aym == 0 || aym > ht) ? ht : aym;
    end else if (axm == 0 || aym == 0) begin
      ww = wd; hh = ht;
    end else begin
      wc = ht * axm / aym;
      if (wc > 4095) wc = 4095;
      if (wc <= wd) begin
        ww = wc; hh = ht;
      end else begin
        ww = wd;
        hh = wd * aym / axm;
        if (hh > ht) hh = ht;
      end
    end
    hmn = (wd - ww) / 2;
    vmn = (ht - hh) / 2;
    hmx = (hmn + ww - 1 + 4096) % 4096;
    vmx = (vmn + hh - 1 + 4096) % 4096;
  endfunction

  task automatic drive(input int wd, input int ht, input int ax, input int ay);
    @(posedge clk);
    #1;
    w   = 12'(wd);
    h   = 12'(ht);
    arx = 13'(ax);
    ary = 13'(ay);
  endtask

  // Waits for VALID, checking that previously published values stay put meanwhile.
  task automatic wait_valid(input string tag);
    int  n = 0;
    bit  done = 1'b0;
    bit  held = 1'b1;
    while (!done) begin
      @(posedge clk);
      #1;
      n++;
      if (valid && n >= 2) done = 1'b1;
      else begin
        if (!valid && (int'(hmin) != p_hmin || int'(hmax) != p_hmax ||
                       int'(vmin) != p_vmin || int'(vmax) != p_vmax)) held = 1'b0;
        if (n > MaxLat + 4) done = 1'b1;
      end
    end
    check_cond({tag, " latency"}, valid && n <= MaxLat, n, MaxLat);
    check_cond({tag, " hold"}, held, int'(held), 1);
  endtask

  task automatic expect_out(input string tag, input int e0, input int e1, input int e2,
                            input int e3);
    check({tag, " hmin"}, int'(hmin), e0);
    check({tag, " hmax"}, int'(hmax), e1);
    check({tag, " vmin"}, int'(vmin), e2);
    check({tag, " vmax"}, int'(vmax), e3);
    p_hmin = e0; p_hmax = e1; p_vmin = e2; p_vmax = e3;
  endtask

  initial begin
    int wd, ht, ax, ay, e0, e1, e2, e3;

    tbl[0]  = '{1920, 1080, 4, 3,           240, 1679, 0, 1079};
    tbl[1]  = '{1280, 1024, 16, 9,          0, 1279, 152, 871};
    tbl[2]  = '{1920, 1080, 'h1500, 'h13c0, 320, 1599, 60, 1019};
    tbl[3]  = '{1920, 1080, 0, 3,           0, 1919, 0, 1079};
    tbl[4]  = '{1920, 1080, 'h1fff, 'h17d0, 0, 1919, 0, 1079};
    tbl[5]  = '{0, 1080, 4, 3,              0, 0, 0, 0};
    tbl[6]  = '{800, 600, 'h1000, 'h1000,   0, 799, 0, 599};
    tbl[7]  = '{1920, 1080, 1, 1,           420, 1499, 0, 1079};
    tbl[8]  = '{640, 480, 3, 4,             140, 499, 0, 479};
    tbl[9]  = '{4000, 4095, 4095, 1,        0, 3999, 2047, 2046};
    tbl[10] = '{1920, 1080, 16, 9,          0, 1919, 0, 1079};
    tbl[11] = '{1920, 0, 'h1500, 'h13c0,    0, 0, 0, 0};

    RESET = 1'b1;
    w = '0; h = '0; arx = '0; ary = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset valid", int'(valid), 0);
    expect_out("reset", 0, 0, 0, 0);
    RESET = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].wd, tbl[i].ht, tbl[i].ax, tbl[i].ay);
      wait_valid($sformatf("vec%0d", i));
      expect_out($sformatf("vec%0d", i), tbl[i].hmn, tbl[i].hmx, tbl[i].vmn, tbl[i].vmx);
    end

    // Abort: 4:3 result published, start 1:1, switch to 16:9 five cycles into MUL1.
    drive(1920, 1080, 4, 3);
    wait_valid("abort base");
    expect_out("abort base", 240, 1679, 0, 1079);
    drive(1920, 1080, 4, 4);
    repeat (7) @(posedge clk);
    #1;
    arx = 13'd16;
    ary = 13'd9;
    @(posedge clk);
    #1;
    check("abort valid low", int'(valid), 0);
    check("abort held hmin", int'(hmin), 240);
    check("abort held hmax", int'(hmax), 1679);
    wait_valid("abort");
    expect_out("abort", 0, 1919, 0, 1079);

    // Reset pulse while DIV1 is running.
    drive(1920, 1080, 4, 3);
    repeat (16) @(posedge clk);
    #1;
    RESET = 1'b1;
    @(posedge clk);
    #1;
    RESET = 1'b0;
    check("midrst valid", int'(valid), 0);
    expect_out("midrst", 0, 0, 0, 0);
    wait_valid("post rst");
    expect_out("post rst", 240, 1679, 0, 1079);

    for (int i = 0; i < 60; i++) begin
      wd = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 4095));
      ht = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 4095));
      case ($urandom_range(0, 3))
        0:       ax = 4096 + int'($urandom_range(0, 4095));
        1:       ax = int'($urandom_range(0, 20));
        default: ax = int'($urandom_range(0, 8191));
      endcase
      ay = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 20))
                                       : int'($urandom_range(0, 8191));
      ref_win(wd, ht, ax, ay, e0, e1, e2, e3);
      drive(wd, ht, ax, ay);
      wait_valid($sformatf("rnd%0d", i));
      expect_out($sformatf("rnd%0d", i), e0, e1, e2, e3);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
